// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared timing defaults, debounce FSM encoding and counter sizing
package game_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYC = 1000000;
  localparam int unsigned DEF_REPEAT_DLY   = 30000000;
  localparam int unsigned DEF_REPEAT_PER   = 10000000;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_fsm_e;

  // Wide enough to hold the largest constant itself, since the repeat counter must reach it.
  function automatic int cnt_width(input int unsigned a, input int unsigned b, input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, 4-state debounce FSM and registered press pulse
module btn_debounce
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int          CNT_W        = 20
) (
  input  logic clk,
  input  logic clk_rst,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam bit               SINGLE = (DEBOUNCE_CYC <= 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  btn_fsm_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

  // The cycle that leaves a stable state already counts as the first stable sample.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      ST_RELEASED: begin
        if (sync2_q) begin
          cnt_d = '0;
          if (SINGLE) begin
            state_d = ST_PRESSED;
            pulse_d = 1'b1;
          end else begin
            state_d = ST_PRESS_WAIT;
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_RELEASED;
        end else if (cnt_inc == LAST) begin
          state_d = ST_PRESSED;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_PRESSED: begin
        if (!sync2_q) begin
          cnt_d   = '0;
          state_d = SINGLE ? ST_RELEASED : ST_RELEASE_WAIT;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = ST_PRESSED;
        end else if (cnt_inc == LAST) begin
          state_d = ST_RELEASED;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_RELEASED;
    endcase
    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
  end

  always_ff @(posedge clk) begin
    if (clk_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  assign level       = level_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - four debounced buttons, move arbitration and shoot auto-repeat
module btn_conditioner
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DLY   = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_PER   = DEF_REPEAT_PER
) (
  input  logic       clk,
  input  logic       clk_rst,
  input  logic       cont_btn,
  input  logic       move_rt_btn,
  input  logic       move_lft_btn,
  input  logic       shoot_btn,
  output logic       cont_pulse,
  output logic       move_rt,
  output logic       move_lft,
  output logic       shoot_pulse,
  output logic [3:0] btn_state
);

  localparam int               CNT_W   = cnt_width(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER);
  localparam logic [CNT_W-1:0] DLY_CNT = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0] PER_CNT = CNT_W'(REPEAT_PER);

  logic [3:0] raw_vec;
  logic [3:0] lvl_vec;
  logic [3:0] pulse_vec;
  logic       shoot_lvl;
  logic       unused_move_pulses;

  assign raw_vec = {cont_btn, move_rt_btn, move_lft_btn, shoot_btn};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_debounce (
      .clk        (clk),
      .clk_rst    (clk_rst),
      .btn_raw    (raw_vec[i]),
      .level      (lvl_vec[i]),
      .press_pulse(pulse_vec[i])
    );
  end

  assign shoot_lvl          = lvl_vec[0];
  assign unused_move_pulses = ^pulse_vec[2:1];

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_per_q, rep_per_d;
  logic [CNT_W-1:0] rep_target;
  logic             rep_hit;

  // rep_cnt counts cycles since the last shoot pulse; gating by the level blocks a pulse on release.
  always_comb begin
    rep_target = rep_per_q ? PER_CNT : DLY_CNT;
    rep_hit    = shoot_lvl && (rep_cnt_q == rep_target);
    rep_per_d  = rep_per_q;
    if (!shoot_lvl) begin
      rep_cnt_d = '0;
      rep_per_d = 1'b0;
    end else if (rep_hit) begin
      rep_cnt_d = CNT_W'(1);
      rep_per_d = 1'b1;
    end else begin
      rep_cnt_d = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clk_rst) begin
      rep_cnt_q <= '0;
      rep_per_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_per_q <= rep_per_d;
    end
  end

  assign cont_pulse  = pulse_vec[3];
  assign move_rt     = lvl_vec[2] & ~lvl_vec[1];
  assign move_lft    = lvl_vec[1] & ~lvl_vec[2];
  assign shoot_pulse = pulse_vec[0] | rep_hit;
  assign btn_state   = lvl_vec;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed self-checking bench for btn_conditioner
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       clk_rst;
  logic       cont_btn, move_rt_btn, move_lft_btn, shoot_btn;
  logic       cont_pulse, move_rt, move_lft, shoot_pulse;
  logic [3:0] btn_state;
  logic       d1_idle, d1_shoot_btn;
  logic       d1_cont_pulse, d1_move_rt, d1_move_lft, d1_shoot_pulse;
  logic [3:0] d1_btn_state;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  btn_conditioner #(.DEBOUNCE_CYC(4), .REPEAT_DLY(20), .REPEAT_PER(8)) dut (
    .clk(clk), .clk_rst(clk_rst),
    .cont_btn(cont_btn), .move_rt_btn(move_rt_btn), .move_lft_btn(move_lft_btn), .shoot_btn(shoot_btn),
    .cont_pulse(cont_pulse), .move_rt(move_rt), .move_lft(move_lft), .shoot_pulse(shoot_pulse),
    .btn_state(btn_state)
  );

  btn_conditioner #(.DEBOUNCE_CYC(1), .REPEAT_DLY(5), .REPEAT_PER(3)) dut_d1 (
    .clk(clk), .clk_rst(clk_rst),
    .cont_btn(d1_idle), .move_rt_btn(d1_idle), .move_lft_btn(d1_idle), .shoot_btn(d1_shoot_btn),
    .cont_pulse(d1_cont_pulse), .move_rt(d1_move_rt), .move_lft(d1_move_lft), .shoot_pulse(d1_shoot_pulse),
    .btn_state(d1_btn_state)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    clk_rst = 1'b1;
    cont_btn = 1'b1; move_rt_btn = 1'b0; move_lft_btn = 1'b0; shoot_btn = 1'b0;
    d1_idle = 1'b0; d1_shoot_btn = 1'b0;
    tick(3);
    check("rst_btn_state", btn_state, 4'b0000);
    check("rst_outputs", {cont_pulse, move_rt, move_lft, shoot_pulse}, 4'b0000);
    check("rst_d1_outputs", {d1_cont_pulse, d1_move_rt, d1_move_lft, d1_shoot_pulse}, 4'b0000);

    // cont held through reset release: one press exactly 6 cycles later
    clk_rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("cont_hold_pulse_%0d", k), cont_pulse, (k == 6));
      check($sformatf("cont_hold_lvl_%0d", k), btn_state[3], (k >= 6));
    end
    cont_btn = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check($sformatf("cont_rel_lvl_%0d", k), btn_state[3], (k < 6));
      check($sformatf("cont_rel_pulse_%0d", k), cont_pulse, 1'b0);
    end

    // clean shoot press, auto-repeat, then release timed onto a repeat slot
    shoot_btn = 1'b1;
    tick(5);
    check("shoot_early_pulse", shoot_pulse, 1'b0);
    check("shoot_early_state", btn_state, 4'b0000);
    tick(1);
    check("shoot_press_pulse", shoot_pulse, 1'b1);
    check("shoot_press_state", btn_state, 4'b0001);
    check("shoot_press_cont", cont_pulse, 1'b0);
    for (int k = 1; k <= 54; k++) begin
      tick(1);
      check($sformatf("shoot_rep_%0d", k), shoot_pulse,
            (k == 20 || k == 28 || k == 36 || k == 44 || k == 52));
    end
    shoot_btn = 1'b0;
    for (int k = 55; k <= 62; k++) begin
      tick(1);
      check($sformatf("shoot_rel_pulse_%0d", k), shoot_pulse, 1'b0);
      check($sformatf("shoot_rel_lvl_%0d", k), btn_state[0], (k < 60));
    end

    // move_rt bounce 1,0,1 on 2-cycle steps, then steady
    move_rt_btn = 1'b1;
    tick(2);
    move_rt_btn = 1'b0;
    tick(2);
    move_rt_btn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check($sformatf("bounce_rt_%0d", k), move_rt, (k >= 6));
    end

    // both moves held cancel each other
    move_lft_btn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check($sformatf("both_rt_%0d", k), move_rt, (k < 6));
      check($sformatf("both_lft_%0d", k), move_lft, 1'b0);
      check($sformatf("both_state_%0d", k), btn_state[2:1], (k >= 6) ? 2'b11 : 2'b10);
    end
    move_lft_btn = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check($sformatf("lft_rel_rt_%0d", k), move_rt, (k >= 6));
      check($sformatf("lft_rel_lft_%0d", k), move_lft, 1'b0);
    end
    move_rt_btn = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check($sformatf("rt_rel_%0d", k), move_rt, (k < 6));
    end

    // DEBOUNCE_CYC = 1: three-cycle latency, repeat at 5 then every 3
    d1_shoot_btn = 1'b1;
    tick(2);
    check("d1_early_pulse", d1_shoot_pulse, 1'b0);
    check("d1_early_state", d1_btn_state, 4'b0000);
    tick(1);
    check("d1_press_pulse", d1_shoot_pulse, 1'b1);
    check("d1_press_state", d1_btn_state, 4'b0001);
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      check($sformatf("d1_rep_%0d", k), d1_shoot_pulse, (k == 5 || k == 8));
    end
    d1_shoot_btn = 1'b0;
    for (int k = 10; k <= 13; k++) begin
      tick(1);
      check($sformatf("d1_rel_lvl_%0d", k), d1_btn_state[0], (k < 12));
      check($sformatf("d1_rel_pulse_%0d", k), d1_shoot_pulse, (k == 11));
    end

    // reset in the middle of PRESS_WAIT aborts the press
    cont_btn = 1'b1;
    shoot_btn = 1'b1;
    tick(4);
    clk_rst = 1'b1;
    tick(1);
    check("pw_rst_state", btn_state, 4'b0000);
    check("pw_rst_outputs", {cont_pulse, move_rt, move_lft, shoot_pulse}, 4'b0000);
    clk_rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("pw_rst_cont_%0d", k), cont_pulse, (k == 6));
      check($sformatf("pw_rst_shoot_%0d", k), shoot_pulse, (k == 6));
    end

    // reset in the middle of auto-repeat aborts the repeat
    tick(10);
    clk_rst = 1'b1;
    tick(1);
    check("rep_rst_state", btn_state, 4'b0000);
    check("rep_rst_outputs", {cont_pulse, move_rt, move_lft, shoot_pulse}, 4'b0000);
    cont_btn = 1'b0;
    shoot_btn = 1'b0;
    clk_rst = 1'b0;
    tick(12);
    check("rep_rst_quiet", {cont_pulse, move_rt, move_lft, shoot_pulse}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
